// File: rtl/and_reduce_ctrl_pkg.sv
// Shared constants for the AND-reduction sequencer: state encoding and default widths.
package and_reduce_ctrl_pkg;

   localparam int unsigned DEF_W  = 8;
   localparam int unsigned DEF_CW = 4;

   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_ACC  = 2'd1;
   localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage : and_reduce_ctrl_pkg

// File: rtl/and_reduce_ctrl_and_unit.sv
// Shared bitwise-AND step, reused every cycle by the reduction sequencer.
module and_unit #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = a & b;

endmodule : and_unit

// File: rtl/and_reduce_ctrl.sv
// Reduces n_ops operand words from a valid/ready stream to their bitwise AND,
// presenting the result on y with a one-cycle done_tick.
module and_reduce_ctrl
   import and_reduce_ctrl_pkg::*;
#(
   parameter int unsigned W  = DEF_W,
   parameter int unsigned CW = DEF_CW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [CW-1:0] n_ops,
   input  logic [W-1:0]  din,
   input  logic          din_valid,
   output logic          din_ready,
   output logic          busy,
   output logic          done_tick,
   output logic [W-1:0]  y
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [W-1:0]       acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [W-1:0]       y_q, y_d;
   logic               done_tick_q, done_tick_d;
   logic               busy_q, busy_d;

   logic [W-1:0]       and_out;
   logic               xfer;

   // Single AND step shared between the accumulator and the result register.
   and_unit #(.W(W)) u_and_unit (
      .a (acc_q),
      .b (din),
      .y (and_out)
   );

   assign din_ready = (state_q == ST_ACC);
   assign xfer      = din_ready && din_valid;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      y_d         = y_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d = '1;
               cnt_d = n_ops;
               if (n_ops == CW'(0)) begin
                  y_d     = '1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ACC;
               end
            end
         end
         ST_ACC: begin
            if (xfer) begin
               acc_d = and_out;
               cnt_d = cnt_q - CW'(1);
               // Exit on the last word so cnt never wraps below zero.
               if (cnt_q == CW'(1)) begin
                  y_d     = and_out;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Moore outputs registered from the next state so they align with state_q.
      done_tick_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '1;
         cnt_q       <= '0;
         y_q         <= '0;
         done_tick_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         y_q         <= y_d;
         done_tick_q <= done_tick_d;
         busy_q      <= busy_d;
      end
   end

   assign y         = y_q;
   assign done_tick = done_tick_q;
   assign busy      = busy_q;

endmodule : and_reduce_ctrl

// File: tb/tb_and_reduce_ctrl.sv
// Directed bench for and_reduce_ctrl: hand-computed results, latencies and transfer counts.
module tb_and_reduce_ctrl;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [3:0] n_ops;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       busy;
   logic       done_tick;
   logic [7:0] y;

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0] wq [16];

   and_reduce_ctrl #(.W(8), .CW(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .n_ops     (n_ops),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .busy      (busy),
      .done_tick (done_tick),
      .y         (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one operation from wq; returns latency in cycles after the start edge (-1 on timeout).
   task automatic run_op(input int n, input int gap, input bit poke,
                         output int xf, output int lat, output int last_k,
                         output bit rdy_seen, output bit busy_ok);
      int k;
      int idx;
      int g;
      xf = 0; lat = -1; last_k = -1; rdy_seen = 1'b0; busy_ok = 1'b1;
      idx = 0; g = gap;
      start = 1'b1;
      n_ops = 4'(n);
      step();
      start = 1'b0;
      for (k = 1; k <= 40; k++) begin
         if (done_tick) begin
            lat = k;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         if (poke && k == 2) begin
            start = 1'b1;
            n_ops = 4'd1;
         end else begin
            start = 1'b0;
         end
         if (g > 0) begin
            din_valid = 1'b0;
            g--;
         end else begin
            din_valid = 1'b1;
            din       = wq[idx & 15];
         end
         if (din_ready) rdy_seen = 1'b1;
         if (din_valid && din_ready) begin
            xf++;
            idx++;
            last_k = k;
         end
         step();
      end
      start = 1'b0;
      // Zero word kept valid through DONE/IDLE; accepting it would clear the next result.
      din_valid = 1'b1;
      din       = 8'h00;
   endtask

   int  xf, lat, last_k;
   bit  rdy_seen, busy_ok;

   initial begin
      reset_n = 1'b0; start = 1'b0; n_ops = 4'd0; din = 8'h00; din_valid = 1'b0;
      step();
      step();
      check("rst_y",         32'(y),         32'h00);
      check("rst_busy",      32'(busy),      32'h0);
      check("rst_done",      32'(done_tick), 32'h0);
      check("rst_din_ready", 32'(din_ready), 32'h0);
      reset_n = 1'b1;
      step();

      // 0xF0 & 0x3C & 0xFF
      wq[0] = 8'hF0; wq[1] = 8'h3C; wq[2] = 8'hFF;
      run_op(3, 0, 1'b0, xf, lat, last_k, rdy_seen, busy_ok);
      check("op3_y",    32'(y),  32'h30);
      check("op3_lat",  32'(lat), 32'd4);
      check("op3_xfer", 32'(xf), 32'd3);
      check("op3_busy", 32'(busy_ok), 32'h1);
      step();
      check("op3_done_pulse", 32'(done_tick), 32'h0);
      check("op3_idle_busy",  32'(busy),      32'h0);
      check("op3_y_hold",     32'(y),         32'h30);

      // Zero operands: identity result, no handshake
      run_op(0, 0, 1'b0, xf, lat, last_k, rdy_seen, busy_ok);
      check("op0_y",     32'(y),        32'hFF);
      check("op0_lat",   32'(lat),      32'd1);
      check("op0_ready", 32'(rdy_seen), 32'h0);
      check("op0_xfer",  32'(xf),       32'd0);
      step();

      // Single word after a two-cycle valid gap
      wq[0] = 8'hA5;
      run_op(1, 2, 1'b0, xf, lat, last_k, rdy_seen, busy_ok);
      check("op1_y",    32'(y),        32'hA5);
      check("op1_lat",  32'(lat),      32'd4);
      check("op1_done_after_xfer", 32'(lat - last_k), 32'd1);
      check("op1_busy", 32'(busy_ok),  32'h1);
      step();

      // start pulsed mid-operation must be ignored
      wq[0] = 8'hF0; wq[1] = 8'h3C; wq[2] = 8'hFF;
      run_op(3, 0, 1'b1, xf, lat, last_k, rdy_seen, busy_ok);
      check("poke_y",    32'(y),   32'h30);
      check("poke_xfer", 32'(xf),  32'd3);
      check("poke_lat",  32'(lat), 32'd4);
      step();
      check("poke_no_restart", 32'(busy), 32'h0);
      step();

      // Maximum operand count with one cleared bit at word 9
      for (int i = 0; i < 16; i++) wq[i] = 8'hFF;
      wq[8] = 8'h7F;
      run_op(15, 0, 1'b0, xf, lat, last_k, rdy_seen, busy_ok);
      check("op15_y",    32'(y),   32'h7F);
      check("op15_xfer", 32'(xf),  32'd15);
      check("op15_lat",  32'(lat), 32'd16);
      step();

      // Reset after two of three words
      din_valid = 1'b0;
      start = 1'b1; n_ops = 4'd3;
      step();
      start = 1'b0;
      din_valid = 1'b1; din = 8'hF0;
      step();
      din = 8'h3C;
      step();
      din_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("abort_y",     32'(y),         32'h00);
      check("abort_busy",  32'(busy),      32'h0);
      check("abort_ready", 32'(din_ready), 32'h0);
      check("abort_done",  32'(done_tick), 32'h0);
      step();
      reset_n = 1'b1;
      step();
      check("post_rst_done", 32'(done_tick), 32'h0);
      check("post_rst_busy", 32'(busy),      32'h0);
      wq[0] = 8'h0F; wq[1] = 8'hFF;
      run_op(2, 0, 1'b0, xf, lat, last_k, rdy_seen, busy_ok);
      check("op2_y",   32'(y),   32'h0F);
      check("op2_lat", 32'(lat), 32'd3);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule : tb_and_reduce_ctrl

// File: doc/and_reduce_ctrl.md
Name: and_reduce_ctrl

Overview:
- Sequencer that reduces a stream of operand words to one word using a single shared bitwise-AND step, one word per accepted transfer: y = w0 & w1 & ... & w(n-1).
- The combinational AND datapath is instantiated once and reused every cycle under FSM control.
- Sits between an operand source (valid/ready stream) and a consumer that samples the result on a done tick.
- The operand count is programmed per operation at start.

Parameters:
- W, 8, data width of operands and result (W >= 1).
- CW, 4, width of the operand-count input; max operands per operation = 2^CW - 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous reset, active low.
- start  input  1  request a new reduction; sampled only in IDLE.
- n_ops  input  CW  number of operands for this operation; sampled with start.
- din  input  W  operand word.
- din_valid  input  1  din holds a valid operand.
- din_ready  output  1  block accepts din this cycle.
- busy  output  1  high in any state other than IDLE.
- done_tick  output  1  one-cycle pulse; y holds the new result in the same cycle.
- y  output  W  registered result; holds its value until the next done_tick.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active low, reset_n. Every register is cleared on reset_n low, independent of clk.
- Reset values: state = IDLE, acc = all ones, cnt = 0, y = 0, done_tick = 0, din_ready = 0, busy = 0.
- FSM states: IDLE, ACC, DONE. All outputs are Moore, except that din_ready is a pure decode of state == ACC.
- IDLE:
  - On start = 1: acc <= all ones (AND identity), cnt <= n_ops.
  - If n_ops == 0: next state DONE, y <= all ones. Otherwise next state ACC.
- ACC:
  - din_ready = 1.
  - A transfer occurs when din_valid and din_ready are both high. On a transfer: acc <= acc & din, cnt <= cnt - 1.
  - If cnt == 1 on a transfer: y <= acc & din and next state DONE.
  - No transfer: hold acc and cnt. din_valid gaps of any length are allowed.
- DONE: done_tick = 1 for exactly one cycle, din_ready = 0, then unconditionally return to IDLE.
- Latency: with start at cycle t and din_valid held high:
  - Words are accepted at t+1 .. t+n.
  - done_tick fires at t+n+1.
  - For n_ops = 0, done_tick fires at t+1.
- start while busy is ignored; it is neither queued nor allowed to alter n_ops.
- start is level-sampled. If start is still high in the IDLE cycle after DONE, a new operation begins.
- din is ignored whenever din_ready = 0, including din_valid high in IDLE or DONE.
- Reset mid-operation aborts the operation. y returns to 0, no done_tick is emitted, and any partially accumulated words are discarded.
- Width rules:
  - All AND operations are bitwise and W wide.
  - cnt is CW bits and never underflows, because exit occurs at cnt == 1.
  - n_ops = 2^CW - 1 is legal.

Decomposition:
- Shared package: state encoding constants (IDLE, ACC, DONE) and the default W/CW values.
- One natural sub-module, and_unit: purely combinational, W-bit, out = a & b. It is instantiated once and fed by acc and din; its output drives both the acc and y next-state logic.
- Everything else (FSM, counter, acc, y) stays in and_reduce_ctrl.

Test Plan:
- W=8. start with n_ops=3, words 0xF0, 0x3C, 0xFF with din_valid held high -> words accepted on 3 consecutive cycles; done_tick at start+4; y=0x30.
- start with n_ops=0 -> din_ready never asserts; done_tick at start+1; y=0xFF.
- n_ops=1, word 0xA5 with din_valid low for 2 cycles before the transfer -> y=0xA5; done_tick 1 cycle after the transfer; busy high throughout.
- During the 0xF0, 0x3C, 0xFF operation, pulse start with n_ops=1 in ACC -> ignored; y=0x30; exactly 3 transfers occur.
- Assert reset_n low after 2 of 3 words, then run n_ops=2 with 0x0F, 0xFF -> immediate return to reset values with no done_tick; the next operation gives y=0x0F.
- n_ops=15 (CW=4), all words 0xFF except 0x7F at word 9 -> y=0x7F; exactly 15 transfers.
